// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard-controller signals that the 5-stage pipeline exchanges
// with its central stall/flush sequencer.
//
// Hazard inputs (pipeline -> controller):
//   rd_ex, rn_id, rm_id   register indices of EX destination / ID sources
//   mem_read_ex           EX-stage instruction is a load
//   mem_req_mem           MEM-stage instruction accesses data memory
//   dmem_ready            data memory completes its access this cycle
//   branch_taken_mem      taken branch resolved in MEM
//   stall_cnt_clr         synchronous clear of the stall-cycle counter
// Control outputs (controller -> pipeline):
//   pc_we, ifid_we        front-end write enables
//   idex_bubble           zero the ID/EX control lines
//   ifid_flush, idex_flush, exmem_flush   squash younger instructions
//   pipe_freeze           hold ID/EX, EX/MEM and MEM/WB
//   mem_error             sticky data-memory timeout flag
//   stall_cnt             saturating count of cycles with pc_we=0
//   state                 sequencer state (RUN/LU_STALL/MEM_WAIT/ERROR)
//
// Modports: slave = the controller, master = the pipeline side.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] rd_ex;
   logic [REG_W-1:0] rn_id;
   logic [REG_W-1:0] rm_id;
   logic             mem_read_ex;
   logic             mem_req_mem;
   logic             dmem_ready;
   logic             branch_taken_mem;
   logic             stall_cnt_clr;

   logic             pc_we;
   logic             ifid_we;
   logic             idex_bubble;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             pipe_freeze;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       state;

   modport slave (
      input  rd_ex, rn_id, rm_id, mem_read_ex, mem_req_mem, dmem_ready,
             branch_taken_mem, stall_cnt_clr,
      output pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush,
             pipe_freeze, mem_error, stall_cnt, state
   );

   modport master (
      output rd_ex, rn_id, rm_id, mem_read_ex, mem_req_mem, dmem_ready,
             branch_taken_mem, stall_cnt_clr,
      input  pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush,
             pipe_freeze, mem_error, stall_cnt, state
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Merges load-use,
// data-memory-wait and taken-branch hazards into one set of pipeline-register
// enables/flushes with fixed priority (mem wait > branch > load-use), adds a
// one-shot load-use stall, a memory-wait timeout that parks the pipe in a
// sticky ERROR state, and a saturating count of stalled cycles.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   hz_if    pipeline_hazard_ctrl_if.slave: hazard inputs, control outputs
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int ZERO_REG    = 31,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   pipeline_hazard_ctrl_if.slave         hz_if
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
   localparam logic [REG_W-1:0]  ZERO_V    = REG_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_cnt_next;
   logic                r_mem_error;
   logic                w_mem_error_next;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic w_hz_lu;
   logic w_hz_mem;
   logic w_pc_we;
   logic w_ifid_we;
   logic w_idex_bubble;
   logic w_flush;
   logic w_pipe_freeze;

   // XZR as destination never produces a real dependency.
   assign w_hz_lu  = hz_if.mem_read_ex && (hz_if.rd_ex != ZERO_V) &&
                     ((hz_if.rd_ex == hz_if.rn_id) || (hz_if.rd_ex == hz_if.rm_id));
   assign w_hz_mem = hz_if.mem_req_mem && !hz_if.dmem_ready;

   // -----------------------------------------------------------------------
   // State / counter registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_mem_error <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_wait_cnt  <= w_wait_cnt_next;
         r_mem_error <= w_mem_error_next;
      end
   end

   // Counts every edge on which the PC was held; clear beats increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
      end else if (hz_if.stall_cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (!w_pc_we && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and output decode
   // -----------------------------------------------------------------------
   always_comb begin
      w_state_next     = r_state;
      w_wait_cnt_next  = r_wait_cnt;
      w_mem_error_next = r_mem_error;
      w_pc_we          = 1'b1;
      w_ifid_we        = 1'b1;
      w_idex_bubble    = 1'b0;
      w_flush          = 1'b0;
      w_pipe_freeze    = 1'b0;

      case (r_state)
         RUN, LU_STALL: begin
            if (w_hz_mem) begin
               // A pending branch waits: the freeze holds its MEM-stage inputs.
               w_pc_we         = 1'b0;
               w_ifid_we       = 1'b0;
               w_pipe_freeze   = 1'b1;
               w_state_next    = MEM_WAIT;
               w_wait_cnt_next = WAIT_W'(1);
            end else if (hz_if.branch_taken_mem) begin
               // Younger instructions are squashed, so no load-use bubble.
               w_flush      = 1'b1;
               w_state_next = RUN;
            end else if (w_hz_lu && (r_state == RUN)) begin
               // Only from RUN: the match seen in LU_STALL is the same
               // instruction pair and must not stall twice.
               w_pc_we       = 1'b0;
               w_ifid_we     = 1'b0;
               w_idex_bubble = 1'b1;
               w_state_next  = LU_STALL;
            end else begin
               w_state_next = RUN;
            end
         end

         MEM_WAIT: begin
            if (!hz_if.dmem_ready) begin
               w_pc_we       = 1'b0;
               w_ifid_we     = 1'b0;
               w_pipe_freeze = 1'b1;
               if (r_wait_cnt == TIMEOUT_V) begin
                  w_state_next     = ERROR;
                  w_mem_error_next = 1'b1;
               end else begin
                  w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
               end
            end else begin
               // Release cycle behaves like RUN (load-use may stall here).
               w_wait_cnt_next = '0;
               if (hz_if.branch_taken_mem) begin
                  w_flush      = 1'b1;
                  w_state_next = RUN;
               end else if (w_hz_lu) begin
                  w_pc_we       = 1'b0;
                  w_ifid_we     = 1'b0;
                  w_idex_bubble = 1'b1;
                  w_state_next  = LU_STALL;
               end else begin
                  w_state_next = RUN;
               end
            end
         end

         default: begin
            // ERROR: pipe stays frozen until reset.
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_pipe_freeze = 1'b1;
            w_state_next  = ERROR;
         end
      endcase

      // Held in reset: nothing advances, nothing is flushed.
      if (!reset_n) begin
         w_pc_we       = 1'b0;
         w_ifid_we     = 1'b0;
         w_idex_bubble = 1'b0;
         w_flush       = 1'b0;
         w_pipe_freeze = 1'b1;
      end
   end

   assign hz_if.pc_we       = w_pc_we;
   assign hz_if.ifid_we     = w_ifid_we;
   assign hz_if.idex_bubble = w_idex_bubble;
   assign hz_if.ifid_flush  = w_flush;
   assign hz_if.idex_flush  = w_flush;
   assign hz_if.exmem_flush = w_flush;
   assign hz_if.pipe_freeze = w_pipe_freeze;
   assign hz_if.mem_error   = r_mem_error;
   assign hz_if.stall_cnt   = r_stall_cnt;
   assign hz_if.state       = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int REG_W       = 5;
   localparam int ZERO_REG    = 31;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 3;

   logic clk;
   logic reset_n;

   pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

   pipeline_hazard_ctrl #(
      .REG_W      (REG_W),
      .ZERO_REG   (ZERO_REG),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .hz_if  (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector layout:
   // {pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush,
   //  pipe_freeze, mem_error, state[1:0], stall_cnt[2:0]}
   typedef struct {
      string       name;
      logic [12:0] exp;
   } item_t;

   item_t q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_tx     = 0;

   // Drive one cycle of inputs and queue the expected outputs for that cycle.
   task automatic vec(
      input string      name,
      input logic       rst, mrd,
      input logic [4:0] rd, rn, rm,
      input logic       req, rdy, br, clr,
      input logic       pcwe, ifwe, bub, fl, frz, merr,
      input logic [1:0] st,
      input logic [2:0] cnt
   );
      item_t it;
      @(posedge clk);
      #1;
      reset_n             = rst;
      hz.mem_read_ex      = mrd;
      hz.rd_ex            = rd;
      hz.rn_id            = rn;
      hz.rm_id            = rm;
      hz.mem_req_mem      = req;
      hz.dmem_ready       = rdy;
      hz.branch_taken_mem = br;
      hz.stall_cnt_clr    = clr;
      it.name = name;
      it.exp  = {pcwe, ifwe, bub, fl, fl, fl, frz, merr, st, cnt};
      q.push_back(it);
   endtask

   // Monitor: outputs are valid every cycle; sample mid-cycle on negedge.
   initial begin
      item_t       it;
      logic [12:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            it  = q.pop_front();
            act = {hz.pc_we, hz.ifid_we, hz.idex_bubble, hz.ifid_flush,
                   hz.idex_flush, hz.exmem_flush, hz.pipe_freeze,
                   hz.mem_error, hz.state, hz.stall_cnt};
            n_checks++;
            if (act !== it.exp) begin
               n_fail++;
               $display("FAIL tx %0d %s: got %b required %b (pcwe,ifwe,bub,fl3,frz,merr,st2,cnt3)",
                        n_tx, it.name, act, it.exp);
            end else begin
               $display("tx %0d %s ok state=%0d stall_cnt=%0d", n_tx, it.name,
                        hz.state, hz.stall_cnt);
            end
            n_tx++;
         end
      end
   end

   initial begin
      int guard;
      reset_n             = 1'b0;
      hz.mem_read_ex      = 1'b0;
      hz.rd_ex            = '0;
      hz.rn_id            = 5'd1;
      hz.rm_id            = 5'd2;
      hz.mem_req_mem      = 1'b0;
      hz.dmem_ready       = 1'b1;
      hz.branch_taken_mem = 1'b0;
      hz.stall_cnt_clr    = 1'b0;

      //   name              rst mrd rd  rn  rm req rdy br clr  pc if bu fl fz me st cnt
      vec("reset",            0, 0,  0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
      // Load-use and its one-shot
      vec("lu_stall",         1, 1,  3,  3,  2, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0);
      vec("lu_oneshot",       1, 1,  3,  3,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 1);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 1);
      vec("xzr_no_stall",     1, 1, 31,  1, 31, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 1);
      vec("lu_rn5",           1, 1,  5,  5,  2, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0, 1);
      vec("lu_rn5_held",      1, 1,  5,  5,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 2);
      vec("idle_clr",         1, 0,  0,  1,  2, 0, 1, 0, 1,   1, 1, 0, 0, 0, 0, 0, 2);
      // Memory wait, 3 frozen cycles then release
      vec("mw_enter",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("mw_wait",          1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 1);
      vec("mw_wait",          1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 2);
      vec("mw_release",       1, 0,  0,  1,  2, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 2, 3);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 3);
      // Priority
      vec("br_over_lu",       1, 1,  4,  4,  2, 0, 1, 1, 0,   1, 1, 0, 1, 0, 0, 0, 3);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 3);
      vec("br_with_mem",      1, 0,  0,  1,  2, 1, 0, 1, 0,   0, 0, 0, 0, 1, 0, 0, 3);
      vec("br_after_release", 1, 0,  0,  1,  2, 1, 1, 1, 0,   1, 1, 0, 1, 0, 0, 2, 4);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 4);
      vec("mw_enter2",        1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 4);
      vec("release_lu",       1, 1,  6,  1,  6, 1, 1, 0, 0,   0, 0, 1, 0, 0, 0, 2, 5);
      vec("lu_after_mw",      1, 1,  6,  1,  6, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 6);
      vec("idle_clr",         1, 0,  0,  1,  2, 0, 1, 0, 1,   1, 1, 0, 0, 0, 0, 0, 6);
      // Saturation of the 3-bit stall counter
      vec("sat_enter",        1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("sat_wait",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 1);
      vec("sat_wait",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 2);
      vec("sat_release",      1, 0,  0,  1,  2, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 2, 3);
      vec("sat_enter",        1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 3);
      vec("sat_wait",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 4);
      vec("sat_wait",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 5);
      vec("sat_release",      1, 0,  0,  1,  2, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 2, 6);
      vec("sat_enter",        1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 6);
      vec("sat_wait",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 7);
      vec("sat_hold",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 7);
      vec("sat_clr_on_stall", 1, 0,  0,  1,  2, 1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 2, 7);
      vec("sat_release",      1, 0,  0,  1,  2, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 2, 0);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
      // Timeout after MEM_TIMEOUT cycles in MEM_WAIT
      vec("to_enter",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("to_wait1",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 1);
      vec("to_wait2",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 2);
      vec("to_wait3",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 3);
      vec("to_wait4",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 4);
      vec("error",            1, 0,  0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 3, 5);
      vec("error_ignores_br", 1, 0,  0,  1,  2, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, 3, 6);
      vec("error_sticky",     1, 0,  0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 3, 7);
      vec("reset_from_error", 0, 0,  0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
      // Reset in the middle of a memory wait
      vec("mw_enter3",        1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("mw_wait3",         1, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2, 1);
      vec("reset_mid_mw",     0, 0,  0,  1,  2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
      vec("idle",             1, 0,  0,  1,  2, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);

      // Bounded drain of the scoreboard.
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline; owns the pipeline-register enables.
- Merges three hazard sources into one set of enables/flushes with fixed priority:
  - load-use (EX load feeding ID source),
  - data-memory wait (MEM access not ready),
  - taken branch resolved in MEM.
- Adds a load-use one-shot, a memory-wait timeout and a saturating stall-cycle counter.

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, XZR index; never creates a load-use hazard
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (>=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rd_ex  in  REG_W  EX-stage destination register
rn_id  in  REG_W  ID-stage read register 1
rm_id  in  REG_W  ID-stage read register 2
mem_read_ex  in  1  EX-stage instruction is a load
mem_req_mem  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
branch_taken_mem  in  1  taken branch resolved in MEM
stall_cnt_clr  in  1  synchronous clear of stall_cnt
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
idex_bubble  out  1  zero ID/EX control lines (insert bubble)
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX
exmem_flush  out  1  clear EX/MEM
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
mem_error  out  1  sticky memory timeout
stall_cnt  out  CNT_W  cycles with pc_we=0 (saturating)
state  out  2  RUN=0, LU_STALL=1, MEM_WAIT=2, ERROR=3

Behaviour:
- Reset (async, reset_n=0):
  - state=RUN; wait_cnt=0; stall_cnt=0; mem_error=0.
  - While reset_n=0: pc_we=0, ifid_we=0, pipe_freeze=1, all flushes/bubble 0.
- Defaults: pc_we=1, ifid_we=1, all others 0.
- Hazard conditions:
  - hz_lu = mem_read_ex && rd_ex!=ZERO_REG && (rd_ex==rn_id || rd_ex==rm_id).
  - hz_mem = mem_req_mem && !dmem_ready.
- Priority, combinational, evaluated in RUN and LU_STALL; first match wins:
  1. hz_mem: pc_we=0, ifid_we=0, pipe_freeze=1; next MEM_WAIT, wait_cnt=1.
  2. branch_taken_mem: ifid_flush=idex_flush=exmem_flush=1, pc_we=1 (target load); next RUN. Branch overrides load-use because the younger instructions are squashed.
  3. hz_lu and state==RUN: pc_we=0, ifid_we=0, idex_bubble=1; next LU_STALL.
  4. otherwise: defaults; next RUN.
- LU_STALL:
  - Lasts exactly one cycle. hz_lu is ignored (one-shot), so a stale match cannot double-stall.
  - Rules 1, 2 and 4 still apply.
- MEM_WAIT:
  - While dmem_ready=0: freeze outputs as rule 1; wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT and dmem_ready=0: next ERROR, mem_error<=1.
  - Cycle with dmem_ready=1: freeze released; rules 2–4 evaluated as in RUN (hz_lu allowed); wait_cnt<=0.
- ERROR: freeze outputs permanently; mem_error=1; exits only via reset.
- stall_cnt:
  - +1 on every clk edge where pc_we=0, saturating at 2^CNT_W-1.
  - stall_cnt_clr has priority over increment and zeroes it.
- Outputs are combinational from state and inputs; state and counters are registered. No output depends on a future cycle.
- Simultaneous events:
  - hz_mem+branch: freeze only; branch is re-evaluated once released (inputs held by the freeze).
  - hz_lu+branch: flush only, no bubble.
  - clr+saturation: 0.
- Reset mid-MEM_WAIT or mid-ERROR returns to RUN immediately and clears mem_error.

Test Plan:
- Load-use: RUN, mem_read_ex=1, rd_ex=3, rn_id=3 → same cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle state=1, pc_we=1; stall_cnt=1.
- XZR / one-shot: rd_ex=31=rm_id, mem_read_ex=1 → no stall. rd_ex=5=rn_id held 2 cycles → exactly one stall cycle.
- Mem wait: mem_req_mem=1, dmem_ready=0 for 3 cycles, then 1 → pipe_freeze=1 for 3 cycles; state=2; stall_cnt=3; release cycle pc_we=1, state→RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready stuck 0 → state=3, mem_error=1 after the 4th wait cycle; stays until reset_n=0, which gives state=0, mem_error=0.
- Priority: branch_taken_mem=1 with hz_lu true → three flushes=1, idex_bubble=0, pc_we=1. Branch with hz_mem → freeze only, flushes 0.
- Counter: CNT_W=3, force 9 stall cycles → stall_cnt=7. stall_cnt_clr on a stall cycle → 0.
